// File: rtl/csc_pkg.sv
// Shared definitions for the counter stream checker: FSM state encoding and default sizes.
package csc_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2,
    SLIP   = 2'd3
  } csc_state_e;

  localparam int unsigned CSC_WIDTH    = 3;
  localparam int unsigned CSC_LOCK_N   = 4;
  localparam int unsigned CSC_UNLOCK_N = 2;
  localparam int unsigned CSC_ERRCNT_W = 8;

endpackage

// File: rtl/count_stream_checker_sat_counter.sv
// Saturating up-counter holding at all-ones; a clear takes priority over an increment.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/count_stream_checker.sv
// Locks onto a +1 modulo counter stream and counts mismatches once locked.
// Build option CSC_GAP_TRACK_EN: idle bus cycles advance the expected value instead of dropping lock.
module count_stream_checker
  import csc_pkg::*;
#(
  parameter int unsigned WIDTH    = CSC_WIDTH,
  parameter int unsigned LOCK_N   = CSC_LOCK_N,
  parameter int unsigned UNLOCK_N = CSC_UNLOCK_N,
  parameter int unsigned ERRCNT_W = CSC_ERRCNT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_en,
  input  logic [WIDTH-1:0]    data_in,
  input  logic                err_clr,
  output logic                locked,
  output logic                err_pulse,
  output logic [ERRCNT_W-1:0] err_count,
  output logic [WIDTH-1:0]    expected
);

  localparam int unsigned RUN_W  = $clog2(LOCK_N + 1);
  localparam int unsigned MISS_W = $clog2(UNLOCK_N + 1);

  csc_state_e        state_q, state_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [MISS_W-1:0] miss_q, miss_d;
  logic [WIDTH-1:0]  expected_q, expected_d;
  logic              err_pulse_q, err_pulse_d;
  logic              match;

  assign match = sample_en && (data_in == expected_q);

  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    miss_d      = miss_q;
    expected_d  = expected_q;
    err_pulse_d = 1'b0;

    if ((state_q != HUNT) && !sample_en) begin
`ifdef CSC_GAP_TRACK_EN
      expected_d = expected_q + 1'b1;
`else
      state_d = HUNT;
      run_d   = '0;
      miss_d  = '0;
`endif
    end else begin
      case (state_q)
        HUNT: begin
          if (sample_en) begin
            expected_d = data_in + 1'b1;
            run_d      = RUN_W'(1);
            state_d    = ACQ;
          end
        end
        ACQ: begin
          expected_d = data_in + 1'b1;
          if (match) begin
            run_d = run_q + 1'b1;
            if (run_q == RUN_W'(LOCK_N - 1)) begin
              state_d = LOCKED;
            end
          end else begin
            run_d = RUN_W'(1);
          end
        end
        LOCKED: begin
          if (match) begin
            expected_d = data_in + 1'b1;
          end else begin
            // Freewheel so a single corrupted sample does not shift the reference.
            err_pulse_d = 1'b1;
            expected_d  = expected_q + 1'b1;
            if (UNLOCK_N == 1) begin
              state_d = HUNT;
              run_d   = '0;
              miss_d  = '0;
            end else begin
              miss_d  = MISS_W'(1);
              state_d = SLIP;
            end
          end
        end
        SLIP: begin
          if (match) begin
            expected_d = data_in + 1'b1;
            miss_d     = '0;
            state_d    = LOCKED;
          end else begin
            err_pulse_d = 1'b1;
            expected_d  = expected_q + 1'b1;
            if (miss_q >= MISS_W'(UNLOCK_N - 1)) begin
              state_d = HUNT;
              run_d   = '0;
              miss_d  = '0;
            end else begin
              miss_d = miss_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = HUNT;
          run_d   = '0;
          miss_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      run_q       <= '0;
      miss_q      <= '0;
      expected_q  <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      miss_q      <= miss_d;
      expected_q  <= expected_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  sat_counter #(
    .W(ERRCNT_W)
  ) u_err_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc_i  (err_pulse_d),
    .clr_i  (err_clr),
    .count_o(err_count)
  );

  assign locked    = (state_q == LOCKED) || (state_q == SLIP);
  assign err_pulse = err_pulse_q;
  assign expected  = expected_q;

endmodule
